// File: rtl/space_invaders_pkg.sv
// Shared screen geometry and enemy laser state encoding for the space invaders slice.
package space_invaders_pkg;

  localparam logic [10:0] SCREEN_W      = 11'd640;
  localparam logic [10:0] SCREEN_H      = 11'd480;
  localparam logic [10:0] PLAYER_TOP    = 11'd440;
  localparam logic [10:0] PLAYER_BOTTOM = 11'd455;

  // One-hot so any corrupted encoding is easy to recognise and recover from.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_TRAVEL = 3'b010,
    ST_HIT    = 3'b100
  } enemy_laser_state_e;

endpackage

// File: rtl/laser_tick_gen.sv
// Movement tick divider: counts 0..div_p-1 while enabled and pulses tick_o on the wrap cycle.
// Holding enable low freezes the count; clear_i returns it to zero.
module laser_tick_gen #(
  parameter int div_p = 250000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (div_p > 1) ? $clog2(div_p) : 1;
  localparam logic [CW-1:0] LAST = CW'(div_p - 1);

  logic [CW-1:0] count_q;

  // Tick is combinational so the laser moves on the same edge the count wraps.
  assign tick_o = enable_i && (count_q == LAST);

  // Divider count register; clear wins over counting.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      if (count_q == LAST) count_q <= '0;
      else                 count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/enemy_laser.sv
// Enemy laser: one shot in flight at a time, falls in ticks, hits the player or leaves the screen.
// Optional feature: define ENEMY_LASER_SPEEDUP_EN to add level_i and speed the fall by level.
//
// state  | meaning
// IDLE   | no laser on screen, waiting for fire_i
// TRAVEL | laser falling; collision checked every unfrozen cycle
// HIT    | one cycle, hit_o pulses, then back to IDLE
module enemy_laser
  import space_invaders_pkg::*;
#(
  parameter logic [11:0] color_p    = 12'hF00,
  parameter int          step_div_p = 250000,
  parameter int          step_p     = 4,
  parameter int          len_p      = 10,
  parameter int          width_p    = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
`ifdef ENEMY_LASER_SPEEDUP_EN
  input  logic [1:0] level_i,
`endif
  input  logic       fire_i,
  input  logic [9:0] fire_x_i,
  input  logic [9:0] fire_y_i,
  input  logic       freeze_i,
  input  logic       player_alive_i,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  output logic       fire_ack_o,
  output logic       hit_o,
  output logic       active_o,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_y_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o
);

  enemy_laser_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        ack_q, ack_d;
  logic        in_travel, tick, collide;
  logic [10:0] step_w, laser_right, laser_bottom, miss_bottom;

`ifdef ENEMY_LASER_SPEEDUP_EN
  assign step_w = 11'(step_p) + {9'd0, level_i};
`else
  assign step_w = 11'(step_p);
`endif

  assign in_travel = (state_q == ST_TRAVEL);

  // All geometry sums are widened to 11 bits so nothing wraps near the screen bottom.
  assign laser_right  = {1'b0, x_q} + 11'(width_p - 1);
  assign laser_bottom = {1'b0, y_q} + 11'(len_p - 1);
  assign miss_bottom  = laser_bottom + step_w;

  assign collide = (x_q <= player_right_i) &&
                   (laser_right >= {1'b0, player_left_i}) &&
                   (laser_bottom >= PLAYER_TOP) &&
                   ({1'b0, y_q} <= PLAYER_BOTTOM);

  laser_tick_gen #(
    .div_p(step_div_p)
  ) u_tick (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enable_i  (in_travel & ~freeze_i),
    .clear_i   (~in_travel),
    .tick_o    (tick)
  );

  // Next-state, next-position and acknowledge decode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ack_d   = 1'b0;
    if (!player_alive_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire_i && !freeze_i) begin
            state_d = ST_TRAVEL;
            x_d     = fire_x_i;
            y_d     = fire_y_i;
            ack_d   = 1'b1;
          end
        end
        ST_TRAVEL: begin
          if (!freeze_i) begin
            if (collide) begin
              state_d = ST_HIT;
            end else if (tick) begin
              if (miss_bottom >= SCREEN_H) state_d = ST_IDLE;
              else                         y_d     = y_q + step_w[9:0];
            end
          end
        end
        ST_HIT: begin
          if (!freeze_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, position and acknowledge registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
    end
  end

  assign fire_ack_o    = ack_q;
  assign active_o      = in_travel;
  assign hit_o         = (state_q == ST_HIT) && !freeze_i && player_alive_i;
  assign laser_x_o     = x_q;
  assign laser_y_o     = y_q;
  assign laser_red_o   = color_p[11:8];
  assign laser_green_o = color_p[7:4];
  assign laser_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_enemy_laser.sv
// Self-checking bench for enemy_laser: directed table, multi-cycle corner sequences,
// and randomized traffic against a behavioural model.
module tb_enemy_laser;

  localparam int DIV = 4;
  localparam int STEP = 4;
  localparam int LEN = 10;
  localparam int WID = 2;
  localparam int SCR_H = 480;
  localparam int P_TOP = 440;
  localparam int P_BOT = 455;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fire, freeze, alive;
  logic [9:0] fire_x, fire_y, pl, pr;
  logic       ack, hit, active;
  logic [9:0] lx, ly;
  logic [3:0] red, green, blue;
`ifdef ENEMY_LASER_SPEEDUP_EN
  logic [1:0] level = 2'd0;
`endif

  int errors = 0;
  int checks = 0;

  // behavioural model: mode 0 none, 1 falling, 2 hit
  int m_mode, m_x, m_y, m_phase, m_ack;

  always #5 clk = ~clk;

  enemy_laser #(
    .color_p(12'hF00), .step_div_p(DIV), .step_p(STEP), .len_p(LEN), .width_p(WID)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
`ifdef ENEMY_LASER_SPEEDUP_EN
    .level_i        (level),
`endif
    .fire_i         (fire),
    .fire_x_i       (fire_x),
    .fire_y_i       (fire_y),
    .freeze_i       (freeze),
    .player_alive_i (alive),
    .player_left_i  (pl),
    .player_right_i (pr),
    .fire_ack_o     (ack),
    .hit_o          (hit),
    .active_o       (active),
    .laser_x_o      (lx),
    .laser_y_o      (ly),
    .laser_red_o    (red),
    .laser_green_o  (green),
    .laser_blue_o   (blue)
  );

  typedef struct {
    logic       fire;
    logic [9:0] fx;
    logic [9:0] fy;
    logic       frz;
    logic       alv;
    logic [9:0] exp_x;
    logic [9:0] exp_y;
    logic       exp_ack;
    logic       exp_act;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fire = 0; fire_x = 0; fire_y = 0; freeze = 0; alive = 1; pl = 0; pr = 35;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick_clk();
    tick_clk();
    reset_n = 1;
    m_mode = 0; m_x = 0; m_y = 0; m_phase = 0; m_ack = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit coll;
    coll = (m_x <= int'(pr)) && (m_x + WID - 1 >= int'(pl)) &&
           (m_y + LEN - 1 >= P_TOP) && (m_y <= P_BOT);
    m_ack = 0;
    if (!alive) m_mode = 0;
    else if (m_mode == 0) begin
      if (fire && !freeze) begin
        m_mode = 1; m_x = int'(fire_x); m_y = int'(fire_y); m_phase = 0; m_ack = 1;
      end
    end else if (m_mode == 1 && !freeze) begin
      if (coll) m_mode = 2;
      else if (m_phase == DIV - 1) begin
        m_phase = 0;
        if (m_y + STEP + LEN - 1 >= SCR_H) m_mode = 0;
        else m_y = m_y + STEP;
      end else m_phase++;
    end else if (m_mode == 2 && !freeze) m_mode = 0;
  endtask

  initial begin
    int y_exp, n, t_hit, hits, drop_t, y_at_hit, act_at_hit;
    bit seen;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_ack", ack, 0);
    check("rst_hit", hit, 0);
    check("rst_active", active, 0);
    check("rst_x", lx, 0);
    check("rst_y", ly, 0);
    check("colour", {red, green, blue}, 12'hF00);

    // ---------------- table-driven sequence ----------------
    tbl[0]  = '{1, 300, 100, 0, 1, 300, 100, 1, 1};
    tbl[1]  = '{0,   0,   0, 0, 1, 300, 100, 0, 1};
    tbl[2]  = '{1,  50,  50, 0, 1, 300, 100, 0, 1};
    tbl[3]  = '{1,  60,  60, 0, 1, 300, 100, 0, 1};
    tbl[4]  = '{0,   0,   0, 0, 1, 300, 104, 0, 1};
    tbl[5]  = '{0,   0,   0, 0, 1, 300, 104, 0, 1};
    tbl[6]  = '{0,   0,   0, 0, 1, 300, 104, 0, 1};
    tbl[7]  = '{0,   0,   0, 0, 1, 300, 104, 0, 1};
    tbl[8]  = '{0,   0,   0, 0, 1, 300, 108, 0, 1};
    tbl[9]  = '{1,  70,  70, 1, 1, 300, 108, 0, 1};
    tbl[10] = '{0,   0,   0, 0, 0, 300, 108, 0, 0};
    tbl[11] = '{1,  20,  30, 0, 1,  20,  30, 1, 1};
    for (int i = 0; i < 12; i++) begin
      fire = tbl[i].fire; fire_x = tbl[i].fx; fire_y = tbl[i].fy;
      freeze = tbl[i].frz; alive = tbl[i].alv;
      tick_clk();
      check($sformatf("tbl%0d_x", i), lx, tbl[i].exp_x);
      check($sformatf("tbl%0d_y", i), ly, tbl[i].exp_y);
      check($sformatf("tbl%0d_ack", i), ack, tbl[i].exp_ack);
      check($sformatf("tbl%0d_active", i), active, tbl[i].exp_act);
      check($sformatf("tbl%0d_hit", i), hit, 0);
    end

    // ---------------- async reset mid-flight at y=200 ----------------
    do_reset();
    fire = 1; fire_x = 300; fire_y = 196;
    tick_clk();
    fire = 0;
    for (int i = 0; i < 20 && ly != 10'd200; i++) tick_clk();
    check("rstmid_pre_y", ly, 200);
    #2 reset_n = 0;
    #1;
    check("rstmid_active", active, 0);
    check("rstmid_ack", ack, 0);
    check("rstmid_hit", hit, 0);
    check("rstmid_x", lx, 0);
    check("rstmid_y", ly, 0);
    tick_clk();
    reset_n = 1;
    tick_clk();
    check("rstmid_after_active", active, 0);

    // ---------------- hit on player 290..325 ----------------
    do_reset();
    pl = 290; pr = 325;
    fire = 1; fire_x = 300; fire_y = 420;
    tick_clk();
    fire = 0;
    y_exp = 420;
    while (y_exp + LEN - 1 < P_TOP) y_exp += STEP;
    hits = 0; t_hit = -1; y_at_hit = -1; act_at_hit = -1;
    for (int t = 1; t <= 60; t++) begin
      tick_clk();
      if (hit) begin
        hits++;
        if (t_hit < 0) begin t_hit = t; y_at_hit = int'(ly); act_at_hit = int'(active); end
      end
    end
    check("hit_pulses", hits, 1);
    check("hit_time", t_hit, (y_exp - 420) / STEP * DIV + 1);
    check("hit_y", y_at_hit, y_exp);
    check("hit_active_during", act_at_hit, 0);
    check("hit_active_after", active, 0);

    // ---------------- miss with player 0..35 ----------------
    do_reset();
    fire = 1; fire_x = 300; fire_y = 440;
    tick_clk();
    fire = 0;
    y_exp = 440; n = 0;
    while (y_exp + STEP + LEN - 1 < SCR_H) begin y_exp += STEP; n++; end
    hits = 0; drop_t = -1;
    for (int t = 1; t <= 60 && drop_t < 0; t++) begin
      tick_clk();
      if (hit) hits++;
      if (!active) drop_t = t;
    end
    check("miss_no_hit", hits, 0);
    check("miss_drop_time", drop_t, (n + 1) * DIV);
    check("miss_final_y", ly, y_exp);

    // ---------------- freeze 20 cycles mid-flight ----------------
    do_reset();
    fire = 1; fire_x = 300; fire_y = 100;
    tick_clk();
    fire = 0;
    for (int t = 1; t <= 6; t++) tick_clk();
    freeze = 1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick_clk();
      if (ly != 10'(100 + STEP * (6 / DIV)) || !active || hit) seen = 1;
    end
    check("freeze_hold", seen, 0);
    freeze = 0;
    for (int k = 1; k <= 16; k++) begin
      tick_clk();
      check($sformatf("freeze_resume_%0d", k), ly, 100 + STEP * ((6 + k) / DIV));
    end

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        pl = 10'($urandom_range(0, 600));
        pr = pl + 10'd35;
      end
      fire   = ($urandom_range(0, 9) == 0);
      fire_x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(int'(pl), int'(pl) + 40))
                                           : 10'($urandom_range(0, 639));
      fire_y = 10'($urandom_range(300, 479));
      freeze = ($urandom_range(0, 19) == 0);
      alive  = ($urandom_range(0, 99) != 0);
      #1;
      check("random",
            {ack, active, hit, lx, ly},
            {m_ack[0], (m_mode == 1), (m_mode == 2) && !freeze && alive,
             10'(m_x), 10'(m_y)});
      model_step();
      tick_clk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
